// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: pc register port, execute redirect,
// instruction memory request/response and decode handoff.
// master = fetch unit view, slave = surrounding pipeline/memory view.
interface ifu_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc;
   logic            pc_wen;
   logic [XLEN-1:0] pc_wdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data;
   logic            resp_err;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_fault;

   modport master (
      input  pc, redirect_valid, redirect_pc,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  inst_ready,
      output pc_wen, pc_wdata,
      output req_valid, req_addr,
      output inst_valid, inst, inst_pc, inst_fault
   );

   modport slave (
      output pc, redirect_valid, redirect_pc,
      output req_ready, resp_valid, resp_data, resp_err,
      output inst_ready,
      input  pc_wen, pc_wdata,
      input  req_valid, req_addr,
      input  inst_valid, inst, inst_pc, inst_fault
   );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read, no prefetch buffer.
// Ports: clock, reset_n (async active-low), bus (ifu_if.master).
module ifu #(
   parameter int XLEN    = 32,
   parameter int PC_STEP = 4
) (
   input  logic  clock,
   input  logic  reset_n,
   ifu_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } state_t;

   state_t          state_q, state_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            fault_q, fault_d;

   logic            accept;
   logic            pc_wen;
   logic [XLEN-1:0] pc_wdata;
   logic [XLEN-1:0] next_pc;
   logic            fetch;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         kill_q     <= 1'b0;
         req_addr_q <= '0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         req_addr_q <= req_addr_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      accept   = (state_q == HOLD) && bus.inst_ready;
      // redirect overrides a same-cycle decode accept
      pc_wen   = bus.redirect_valid || accept;
      pc_wdata = bus.redirect_valid ? bus.redirect_pc
                                    : bus.pc + XLEN'(PC_STEP);
      next_pc  = pc_wen ? pc_wdata : bus.pc;

      state_d    = state_q;
      kill_d     = kill_q;
      req_addr_d = req_addr_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      fault_d    = fault_q;
      fetch      = 1'b0;

      unique case (state_q)
         IDLE: fetch = 1'b1;
         REQ: begin
            // request stays up even when killed
            if (bus.redirect_valid) kill_d = 1'b1;
            if (bus.req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.resp_valid) begin
               if (kill_q || bus.redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  inst_d    = bus.resp_data;
                  inst_pc_d = req_addr_q;
                  fault_d   = bus.resp_err;
                  state_d   = HOLD;
               end
            end else if (bus.redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: fetch = pc_wen;
         default: state_d = IDLE;
      endcase

      if (fetch) begin
         req_addr_d = next_pc;
         if (next_pc[1:0] != 2'b00) begin
            // misaligned: report fault without touching memory
            inst_d    = '0;
            inst_pc_d = next_pc;
            fault_d   = 1'b1;
            state_d   = HOLD;
         end else begin
            state_d = REQ;
         end
      end
   end

   assign bus.pc_wen     = pc_wen;
   assign bus.pc_wdata   = pc_wdata;
   assign bus.req_valid  = (state_q == REQ);
   assign bus.req_addr   = req_addr_q;
   assign bus.inst_valid = (state_q == HOLD);
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_fault = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: pc register and memory models,
// expected instructions queued at stimulus, popped at decode.
module tb_ifu;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   ifu_if #(.XLEN(32)) bus ();

   ifu #(.XLEN(32), .PC_STEP(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat = 0;
   int          n_req = 0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] pend_addr = '0;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rdat(input logic [31:0] a);
      return (a == err_addr) ? 32'h0 : memw(a);
   endfunction

   // pc register
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) bus.pc <= 32'h3000_0000;
      else if (bus.pc_wen) bus.pc <= bus.pc_wdata;
   end

   // memory: response lat cycles after the earliest legal slot
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend           <= 1'b0;
         cnt            <= 0;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               bus.resp_valid <= 1'b1;
               bus.resp_data  <= rdat(pend_addr);
               bus.resp_err   <= (pend_addr == err_addr);
               pend           <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            n_req <= n_req + 1;
            if (lat == 0) begin
               bus.resp_valid <= 1'b1;
               bus.resp_data  <= rdat(bus.req_addr);
               bus.resp_err   <= (bus.req_addr == err_addr);
            end else begin
               pend      <= 1'b1;
               pend_addr <= bus.req_addr;
               cnt       <= lat - 1;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic f);
      exp_t e;
      e.pc    = pc;
      e.data  = f ? 32'h0 : memw(pc);
      e.fault = f;
      sb.push_back(e);
   endtask

   task automatic wait_inst();
      exp_t e;
      for (int i = 0; i < 60 && !bus.inst_valid; i++)
         @(negedge clock);
      chk("inst_valid", 32'(bus.inst_valid), 32'd1);
      if (bus.inst_valid) begin
         chk("sb_size", 32'(sb.size()), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("inst_pc", bus.inst_pc, e.pc);
            chk("inst", bus.inst, e.data);
            chk("inst_fault", 32'(bus.inst_fault), 32'(e.fault));
         end
      end
   endtask

   task automatic accept(input logic [31:0] exp_wdata);
      bus.inst_ready = 1'b1;
      #1;
      chk("acc_wen", 32'(bus.pc_wen), 32'd1);
      chk("acc_wdata", bus.pc_wdata, exp_wdata);
      @(negedge clock);
      bus.inst_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tgt;
      #1;
      chk("rd_wen", 32'(bus.pc_wen), 32'd1);
      chk("rd_wdata", bus.pc_wdata, tgt);
      @(negedge clock);
      bus.redirect_valid = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 40 && !bus.req_valid; i++)
         @(negedge clock);
      chk("req_seen", 32'(bus.req_valid), 32'd1);
   endtask

   initial begin
      int nr;
      reset_n            = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.req_ready      = 1'b1;
      bus.inst_ready     = 1'b0;
      #1;
      chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
      chk("rst_req_addr", bus.req_addr, 32'h0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_fault", 32'(bus.inst_fault), 32'd0);
      chk("rst_pc_wen", 32'(bus.pc_wen), 32'd0);

      // basic fetch, zero-wait memory
      push(32'h3000_0000, 1'b0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rel_req_valid", 32'(bus.req_valid), 32'd0);
      @(negedge clock);
      chk("first_req_valid", 32'(bus.req_valid), 32'd1);
      chk("first_req_addr", bus.req_addr, 32'h3000_0000);
      wait_inst();
      bus.req_ready = 1'b0;
      accept(32'h3000_0004);

      // request stall
      push(32'h3000_0004, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("stall_req_valid", 32'(bus.req_valid), 32'd1);
         chk("stall_req_addr", bus.req_addr, 32'h3000_0004);
         chk("stall_pc_wen", 32'(bus.pc_wen), 32'd0);
         @(negedge clock);
      end
      bus.req_ready = 1'b1;
      wait_inst();
      accept(32'h3000_0008);

      // decode stall in HOLD
      push(32'h3000_0008, 1'b0);
      wait_inst();
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("hold_valid", 32'(bus.inst_valid), 32'd1);
         chk("hold_inst", bus.inst, memw(32'h3000_0008));
         chk("hold_pc", bus.inst_pc, 32'h3000_0008);
         chk("hold_pc_wen", 32'(bus.pc_wen), 32'd0);
      end
      lat = 2;
      accept(32'h3000_000C);

      // redirect in WAIT, stale response arrives later
      push(32'h3000_0100, 1'b0);
      chk("kill_req_addr", bus.req_addr, 32'h3000_000C);
      @(negedge clock);
      chk("wait_no_resp", 32'(bus.resp_valid), 32'd0);
      redirect(32'h3000_0100);
      wait_req();
      lat = 0;
      chk("refetch_addr", bus.req_addr, 32'h3000_0100);
      wait_inst();
      accept(32'h3000_0104);

      // redirect in WAIT coincident with response
      push(32'h3000_0200, 1'b0);
      @(negedge clock);
      chk("wait_resp_now", 32'(bus.resp_valid), 32'd1);
      redirect(32'h3000_0200);
      wait_inst();

      // redirect coincident with accept
      push(32'h3000_0300, 1'b0);
      bus.inst_ready = 1'b1;
      redirect(32'h3000_0300);
      bus.inst_ready = 1'b0;
      wait_inst();

      // access fault response
      err_addr = 32'h3000_0304;
      push(32'h3000_0304, 1'b1);
      accept(32'h3000_0304);
      wait_inst();
      push(32'h3000_0308, 1'b0);
      accept(32'h3000_0308);
      wait_inst();

      // misaligned redirect: no memory request
      nr = n_req;
      push(32'h3000_0102, 1'b1);
      redirect(32'h3000_0102);
      wait_inst();
      chk("misalign_no_req", 32'(n_req), 32'(nr));

      // wrap at top of address space
      push(32'hFFFF_FFFC, 1'b0);
      redirect(32'hFFFF_FFFC);
      wait_inst();
      push(32'h0000_0000, 1'b0);
      accept(32'h0000_0000);
      wait_inst();
      accept(32'h0000_0004);
      repeat (4) @(negedge clock);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
